lc3x_mult_div: RTL and testbench



---
 rtl/lc3x_mult_div.sv | 123 ++++++++++++
 tb/tb_lc3x_mult_div.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/lc3x_mult_div.sv
// Iterative signed 16-bit multiply/divide unit for the LC-3x EX stage.
// Shift-add multiply and restoring divide on magnitudes, with the sign fixed up at the end.
module lc3x_mult_div #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             flush,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             div_by_zero
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] CNT_INIT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_e;

  state_e             state_q;
  logic [CW-1:0]      cnt_q;
  logic [2*WIDTH-1:0] acc_q;
  logic [WIDTH-1:0]   opnd_q;
  logic               sign_q;
  logic               dz_q;
  logic               busy_q;
  logic               done_q;
  logic [WIDTH-1:0]   result_q;
  logic               div_by_zero_q;

  logic [WIDTH-1:0]   mag_a, mag_b;
  logic               is_div;
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     div_shift;
  logic [WIDTH:0]     div_diff;
  logic [2*WIDTH-1:0] acc_d;
  logic [WIDTH-1:0]   mag_res;
  logic [WIDTH-1:0]   result_d;

  assign mag_a  = a[WIDTH-1] ? -a : a;
  assign mag_b  = b[WIDTH-1] ? -b : b;
  assign is_div = (op == 2'b10);

  // Multiply keeps the product in acc_q and the multiplier in its low half;
  // divide keeps the remainder in the high half and shifts the quotient into the low half.
  always_comb begin
    mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
    div_shift = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    div_diff  = div_shift - {1'b0, opnd_q};
    if (state_q == DIV) begin
      if (div_shift < {1'b0, opnd_q})
        acc_d = {div_shift[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
      else
        acc_d = {div_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
    end else begin
      acc_d = {mul_sum, acc_q[WIDTH-1:1]};
    end
    mag_res  = acc_d[WIDTH-1:0];
    result_d = dz_q ? '1 : (sign_q ? -mag_res : mag_res);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      acc_q         <= '0;
      opnd_q        <= '0;
      sign_q        <= 1'b0;
      dz_q          <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      result_q      <= '0;
      div_by_zero_q <= 1'b0;
    end else begin
      // NOTE: done_q defaults low every cycle so it can only ever be a one-cycle pulse.
      done_q <= 1'b0;
      if (flush) begin
        state_q <= IDLE;
        cnt_q   <= '0;
        busy_q  <= 1'b0;
      end else begin
        case (state_q)
          IDLE, DONE: begin
            if (start) begin
              state_q <= is_div ? DIV : MUL;
              cnt_q   <= CNT_INIT;
              busy_q  <= 1'b1;
              sign_q  <= a[WIDTH-1] ^ b[WIDTH-1];
              dz_q    <= is_div && (b == '0);
              acc_q   <= {{WIDTH{1'b0}}, (is_div ? mag_a : mag_b)};
              opnd_q  <= is_div ? mag_b : mag_a;
            end else begin
              state_q <= IDLE;
              busy_q  <= 1'b0;
            end
          end
          MUL, DIV: begin
            acc_q <= acc_d;
            cnt_q <= cnt_q - 1'b1;
            if (cnt_q == '0) begin
              state_q       <= DONE;
              cnt_q         <= '0;
              busy_q        <= 1'b0;
              done_q        <= 1'b1;
              result_q      <= result_d;
              div_by_zero_q <= dz_q;
            end
          end
        endcase
      end
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign result      = result_q;
  assign div_by_zero = div_by_zero_q;

endmodule

// File: tb/tb_lc3x_mult_div.sv
// Self-checking bench for lc3x_mult_div: vector table, random ops against a signed
// arithmetic model, and hand sequences for flush, reset, ignored start and back-to-back.
module tb_lc3x_mult_div;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        flush;
  logic [1:0]  op;
  logic [15:0] a, b;
  logic        busy, done, div_by_zero;
  logic [15:0] result;

  lc3x_mult_div #(.WIDTH(16)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .a(a), .b(b), .flush(flush),
    .busy(busy), .done(done), .result(result), .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [15:0] res;
    logic        dz;
  } exp_t;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic [1:0]  op;
    logic [15:0] res;
    logic        dz;
  } vec_t;

  exp_t sb_q[$];
  exp_t last_exp;
  vec_t vecs[13];
  int   checks = 0;
  int   failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  function automatic exp_t model(input logic [15:0] x, input logic [15:0] y, input logic [1:0] o);
    int   sx, sy, r;
    exp_t e;
    sx = int'($signed(x));
    sy = int'($signed(y));
    if (o == 2'b10) begin
      if (sy == 0) begin
        e.res = 16'hFFFF;
        e.dz  = 1'b1;
      end else begin
        r     = sx / sy;
        e.res = r[15:0];
        e.dz  = 1'b0;
      end
    end else begin
      r     = sx * sy;
      e.res = r[15:0];
      e.dz  = 1'b0;
    end
    return e;
  endfunction

  // Leaves the bench at the negedge of cycle 1 after the accepting edge.
  task automatic launch(input logic [15:0] ta, input logic [15:0] tb, input logic [1:0] top,
                        input bit push, input exp_t e);
    @(negedge clk);
    a = ta; b = tb; op = top; start = 1'b1;
    if (push) sb_q.push_back(e);
    @(negedge clk);
    start = 1'b0;
  endtask

  // Called at cycle 1; waits for done, checking busy window and latency.
  // poke > 0 pulses a junk start during that cycle of the operation.
  task automatic collect(input string tag, input int poke);
    int   n = 1;
    bit   busy_ok = 1'b1;
    exp_t e;
    while (!done && n < 40) begin
      if (!busy) busy_ok = 1'b0;
      if (poke > 0) begin
        start = (n == poke);
        if (n == poke) begin a = 16'h0001; b = 16'h0001; op = 2'b10; end
      end
      @(negedge clk);
      n++;
    end
    if (poke > 0) start = 1'b0;
    check({tag, "_done_seen"}, done, 1);
    check({tag, "_busy_window"}, busy_ok, 1);
    check({tag, "_latency"}, n, 17);
    if (done) begin
      check({tag, "_busy_at_done"}, busy, 0);
      if (sb_q.size() == 0) begin
        check({tag, "_sb_depth"}, sb_q.size(), 1);
      end else begin
        e = sb_q.pop_front();
        last_exp = e;
        check({tag, "_result"}, result, e.res);
        check({tag, "_div_by_zero"}, div_by_zero, e.dz);
      end
    end
  endtask

  task automatic watch_no_done(input string tag, input int cycles);
    int seen = 0;
    repeat (cycles) begin
      @(negedge clk);
      if (done) seen++;
    end
    check({tag, "_no_done"}, seen, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    exp_t        e;
    logic [15:0] ra, rb;
    logic [1:0]  ro;

    vecs[0]  = '{16'd7,    16'd6,    2'b01, 16'h002A, 1'b0};
    vecs[1]  = '{16'hFFFD, 16'd5,    2'b01, 16'hFFF1, 1'b0};
    vecs[2]  = '{16'h0100, 16'h0100, 2'b01, 16'h0000, 1'b0};
    vecs[3]  = '{16'd100,  16'd7,    2'b10, 16'h000E, 1'b0};
    vecs[4]  = '{16'hFF9C, 16'd7,    2'b10, 16'hFFF2, 1'b0};
    vecs[5]  = '{16'h8000, 16'hFFFF, 2'b10, 16'h8000, 1'b0};
    vecs[6]  = '{16'd5,    16'd0,    2'b10, 16'hFFFF, 1'b1};
    vecs[7]  = '{16'd3,    16'd3,    2'b01, 16'h0009, 1'b0};
    vecs[8]  = '{16'd7,    16'hFFFE, 2'b10, 16'hFFFD, 1'b0};
    vecs[9]  = '{16'd4,    16'd5,    2'b00, 16'h0014, 1'b0};
    vecs[10] = '{16'd2,    16'hFFFF, 2'b11, 16'hFFFE, 1'b0};
    vecs[11] = '{16'hFFF9, 16'd0,    2'b10, 16'hFFFF, 1'b1};
    vecs[12] = '{16'h8000, 16'hFFFF, 2'b01, 16'h8000, 1'b0};

    rst_n = 1'b0; start = 1'b0; flush = 1'b0; op = 2'b00; a = '0; b = '0;
    last_exp = '0;
    #1;
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_result", result, 16'h0000);
    check("reset_dz", div_by_zero, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 13; i++) begin
      e.res = vecs[i].res;
      e.dz  = vecs[i].dz;
      launch(vecs[i].a, vecs[i].b, vecs[i].op, 1'b1, e);
      collect($sformatf("vec%0d", i), 0);
    end

    for (int i = 0; i < 16; i++) begin
      ra = 16'($urandom);
      rb = (i % 4 == 0) ? 16'($urandom_range(0, 7)) : 16'($urandom);
      ro = ($urandom_range(0, 1) == 1) ? 2'b10 : 2'b01;
      launch(ra, rb, ro, 1'b1, model(ra, rb, ro));
      collect($sformatf("rand%0d", i), 0);
    end

    // Start pulse during MUL must not disturb the operation in flight.
    e.res = 16'h0051; e.dz = 1'b0;
    launch(16'd9, 16'd9, 2'b01, 1'b1, e);
    collect("ignored_start", 5);
    watch_no_done("ignored_start", 20);

    // Flush at cycle 8 discards the operation and keeps the old result.
    launch(16'd3, 16'd4, 2'b01, 1'b0, e);
    repeat (7) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check("flush_idle", busy, 0);
    watch_no_done("flush", 25);
    check("flush_keeps_result", result, last_exp.res);

    // Flush and start together: flush wins.
    @(negedge clk);
    a = 16'd2; b = 16'd2; op = 2'b01; start = 1'b1; flush = 1'b1;
    @(negedge clk);
    start = 1'b0; flush = 1'b0;
    check("flush_beats_start", busy, 0);
    watch_no_done("flush_start", 20);

    // Back-to-back: start held across DONE.
    @(negedge clk);
    a = 16'd12; b = 16'd11; op = 2'b01; start = 1'b1;
    e.res = 16'h0084; e.dz = 1'b0; sb_q.push_back(e);
    @(negedge clk);
    a = 16'hFF38; b = 16'd9; op = 2'b10;
    e.res = 16'hFFEA; e.dz = 1'b0; sb_q.push_back(e);
    collect("b2b_first", 0);
    @(negedge clk);
    start = 1'b0;
    check("b2b_no_bubble", busy, 1);
    collect("b2b_second", 0);

    // Divide by zero sets the flag, then reset mid-operation clears everything.
    e.res = 16'hFFFF; e.dz = 1'b1;
    launch(16'd5, 16'd0, 2'b10, 1'b1, e);
    collect("dz_before_reset", 0);
    launch(16'd5, 16'd5, 2'b01, 1'b0, e);
    repeat (9) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midreset_busy", busy, 0);
    check("midreset_done", done, 0);
    check("midreset_result", result, 16'h0000);
    check("midreset_dz", div_by_zero, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    watch_no_done("after_reset", 25);

    e.res = 16'hFFF6; e.dz = 1'b0;
    launch(16'hFFFE, 16'd5, 2'b01, 1'b1, e);
    collect("post_reset_mul", 0);
    check("sb_drained", sb_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
